serial_subtractor: RTL

//   Bit-serial unsigned subtractor: the subtract-direction counterpart of the gate-level adder cells.

---
 rtl/serial_subtractor.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor slice plus a borrow flop,
// LSB-first, with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] sd_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_next;
  logic             d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Full-subtractor slice; the MSB insert is written as shift-then-overwrite
  // so the same expression holds for WIDTH=1.
  always_comb begin
    d                = sa[0] ^ sb[0] ^ br;
    br_next          = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sd_next          = sd >> 1;
    sd_next[WIDTH-1] = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      sd  <= '0;
      cnt <= '0;
      br  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa  <= a;
            sb  <= b;
            sd  <= '0;
            cnt <= '0;
            br  <= 1'b0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_next;
          br  <= br_next;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign diff   = out_valid ? sd : '0;
  assign borrow = out_valid & br;

endmodule
